// File: rtl/smag_mul_pkg.sv
// ---------------------------------------------------------------------------
// smag_mul_pkg
// Shared definitions for the iterative sign-magnitude multiplier:
//   - smagState_e : controller states (IDLE, BUSY, DONE)
//   - magWidth()  : magnitude width of a W-bit sign-magnitude operand (W-1)
//   - prodWidth() : width of the magnitude product (2W-2)
//   - normSign()  : sign of the product with negative zero folded to +0
// Optional build macro used by the top: SMAG_MUL_EARLY_TERM_EN.
// ---------------------------------------------------------------------------
package smag_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } smagState_e;

    function automatic int magWidth(input int w);
        return w - 1;
    endfunction

    function automatic int prodWidth(input int w);
        return 2 * w - 2;
    endfunction

    // A zero magnitude is always reported as positive so the accumulator
    // downstream never sees a "-0" product.
    function automatic logic normSign(input logic sign, input logic magIsZero);
        return sign & ~magIsZero;
    endfunction

endpackage

// File: rtl/smag_mul_step.sv
// ---------------------------------------------------------------------------
// smag_mul_step
// One combinational shift-add step of the multiplier: when the current
// multiplier bit is set, the multiplicand magnitude shifted left by the step
// index is added to the running accumulator.
// Parameters:
//   W        operand width including sign bit (2..32)
// Ports:
//   i_acc    running accumulator (2W-2 bits)
//   i_magA   multiplicand magnitude (W-1 bits)
//   i_bBit   current multiplier bit
//   i_index  step index (weight of the current multiplier bit)
//   o_acc    accumulator after this step
// ---------------------------------------------------------------------------
module smag_mul_step
    import smag_mul_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [prodWidth(W)-1:0] i_acc,
    input  logic [magWidth(W)-1:0]  i_magA,
    input  logic                    i_bBit,
    input  logic [$clog2(W)-1:0]    i_index,
    output logic [prodWidth(W)-1:0] o_acc
);

    localparam int PW = prodWidth(W);

    logic [PW-1:0] w_addend;

    // The magnitude product fits in 2W-2 bits, so the shifted partial
    // product and the sum can never carry out of the accumulator width.
    always_comb begin
        w_addend = PW'(i_magA) << i_index;
        o_acc    = i_bBit ? (i_acc + w_addend) : i_acc;
    end

endmodule

// File: rtl/smag_seq_multiplier.sv
// ---------------------------------------------------------------------------
// smag_seq_multiplier
// Iterative sign-magnitude multiplier with valid/ready handshakes on both
// sides. Magnitudes are multiplied with a shift-add datapath of W-1 steps;
// the sign is the XOR of the operand signs, forced to 0 for a zero product.
// Parameters:
//   W          operand width including sign bit (2..32)
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   operand pair a/b valid
//   in_ready   block can accept operands (high in IDLE)
//   a, b       multiplicand / multiplier, sign-magnitude, W bits
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   p          product, sign-magnitude, 2W bits (p[2W-2] always 0)
//   busy       high while the shift-add iteration is running
// Build option:
//   SMAG_MUL_EARLY_TERM_EN  finish BUSY as soon as no multiplier bits remain
// ---------------------------------------------------------------------------
module smag_seq_multiplier
    import smag_mul_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p,
    output logic           busy
);

    localparam int MW = magWidth(W);
    localparam int PW = prodWidth(W);
    localparam int CW = $clog2(W);

    smagState_e      r_state;
    smagState_e      w_nextState;
    logic [MW-1:0]   r_magA;
    logic [MW-1:0]   r_magB;
    logic            r_sign;
    logic [PW-1:0]   r_acc;
    logic [CW-1:0]   r_count;
    logic            r_outValid;
    logic [2*W-1:0]  r_p;

    logic [PW-1:0]   w_accNext;
    logic [MW-1:0]   w_magBRest;
    logic            w_lastStep;

    smag_mul_step #(
        .W (W)
    ) u_step (
        .i_acc   (r_acc),
        .i_magA  (r_magA),
        .i_bBit  (r_magB[0]),
        .i_index (r_count),
        .o_acc   (w_accNext)
    );

    assign w_magBRest = r_magB >> 1;

    // The last step is normally fixed at step index W-2. With early
    // termination, the iteration also stops once the multiplier bits still
    // to be consumed are all zero, since further steps cannot change acc.
`ifdef SMAG_MUL_EARLY_TERM_EN
    assign w_lastStep = (r_count == CW'(W - 2)) || (w_magBRest == '0);
`else
    assign w_lastStep = (r_count == CW'(W - 2));
`endif

    // State register; reset drops any operation in flight back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake outputs. in_ready and busy decode directly
    // from the state so operands are never sampled outside IDLE.
    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_nextState = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (w_lastStep) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath registers. Operands are captured once at acceptance, so
    // later changes on a/b have no effect. The product register is written
    // only on the final BUSY edge and otherwise holds its last value, even
    // after the result has been consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_magA     <= '0;
            r_magB     <= '0;
            r_sign     <= 1'b0;
            r_acc      <= '0;
            r_count    <= '0;
            r_outValid <= 1'b0;
            r_p        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_magA  <= a[W-2:0];
                        r_magB  <= b[W-2:0];
                        r_sign  <= a[W-1] ^ b[W-1];
                        r_acc   <= '0;
                        r_count <= '0;
                    end
                end
                BUSY: begin
                    r_acc   <= w_accNext;
                    r_magB  <= w_magBRest;
                    r_count <= r_count + CW'(1);
                    if (w_lastStep) begin
                        r_p        <= {normSign(r_sign, w_accNext == '0), 1'b0, w_accNext};
                        r_outValid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_valid = r_outValid;
    assign p         = r_p;

endmodule

// File: tb/tb_smag_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_smag_seq_multiplier
// Self-checking bench for smag_seq_multiplier: a W=8 instance driven from a
// vector table, hand-written handshake/reset sequences and random operands
// compared against an arithmetic reference, plus a W=4 instance.
// ---------------------------------------------------------------------------
module tb_smag_seq_multiplier;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          inValid;
    logic          inReady;
    logic [W-1:0]  opA;
    logic [W-1:0]  opB;
    logic          outValid;
    logic          outReady;
    logic [2*W-1:0] prodP;
    logic          busy;

    logic          inValid4;
    logic          inReady4;
    logic [3:0]    opA4;
    logic [3:0]    opB4;
    logic          outValid4;
    logic          outReady4;
    logic [7:0]    prodP4;
    logic          busy4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] expP;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    smag_seq_multiplier #(
        .W (W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .a         (opA),
        .b         (opB),
        .out_valid (outValid),
        .out_ready (outReady),
        .p         (prodP),
        .busy      (busy)
    );

    smag_seq_multiplier #(
        .W (4)
    ) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid4),
        .in_ready  (inReady4),
        .a         (opA4),
        .b         (opB4),
        .out_valid (outValid4),
        .out_ready (outReady4),
        .p         (prodP4),
        .busy      (busy4)
    );

    // Reference product: plain multiplication of the magnitudes, sign is the
    // XOR of the operand signs unless the product is zero.
    function automatic logic [15:0] refMul(input logic [7:0] x, input logic [7:0] y);
        int unsigned m;
        logic        s;
        m = int'(x[6:0]) * int'(y[6:0]);
        s = (x[7] != y[7]) && (m != 0);
        return {s, 15'(m)};
    endfunction

    // Edges from driving the operands until out_valid is seen, counting the
    // acceptance edge: 1 + number of BUSY cycles.
    function automatic int refLatency(input logic [7:0] y);
        int top;
        top = 0;
`ifdef SMAG_MUL_EARLY_TERM_EN
        for (int i = 0; i < W - 1; i++) begin
            if (y[i]) top = i + 1;
        end
        return 1 + ((top == 0) ? 1 : top);
`else
        return W + top;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one operand pair, then wait for the result while scrambling
    // a/b and toggling out_ready to show neither affects the operation.
    task automatic applyStimulus(input logic [7:0] xa, input logic [7:0] xb,
                                 output logic [15:0] prod, output int lat, output int busyCnt);
        @(posedge clk); #1;
        checkOutput("in_ready idle", 32'(inReady), 32'h1);
        inValid = 1'b1;
        opA     = xa;
        opB     = xb;
        lat     = 0;
        busyCnt = 0;
        @(posedge clk); #1;
        inValid = 1'b0;
        opA     = 8'($urandom);
        opB     = 8'($urandom);
        lat     = 1;
        if (busy) busyCnt++;
        while (!outValid && lat < 200) begin
            outReady = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
            if (busy) busyCnt++;
        end
        outReady = 1'b0;
        checkOutput("out_valid arrives", 32'(outValid), 32'h1);
        prod = prodP;
    endtask

    task automatic releaseResult();
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        checkOutput("out_valid cleared", 32'(outValid), 32'h0);
        checkOutput("in_ready after release", 32'(inReady), 32'h1);
    endtask

    initial begin
        logic [15:0] gotP;
        logic [7:0]  ra;
        logic [7:0]  rb;
        int          lat;
        int          busyCnt;
        logic        seenValid;
        int          lat4;
        int          busyCnt4;

        vecs[0] = '{8'h05, 8'h83, 16'h800F};
        vecs[1] = '{8'h7F, 8'hFF, 16'hBF01};
        vecs[2] = '{8'h7F, 8'h7F, 16'h3F01};
        vecs[3] = '{8'h80, 8'h85, 16'h0000};
        vecs[4] = '{8'h00, 8'h00, 16'h0000};
        vecs[5] = '{8'h02, 8'h03, 16'h0006};
        vecs[6] = '{8'h81, 8'h81, 16'h0001};
        vecs[7] = '{8'hFF, 8'h01, 16'h807F};

        rst       = 1'b1;
        inValid   = 1'b0;
        outReady  = 1'b0;
        opA       = '0;
        opB       = '0;
        inValid4  = 1'b0;
        outReady4 = 1'b0;
        opA4      = '0;
        opB4      = '0;

        #12;
        checkOutput("reset in_ready", 32'(inReady), 32'h1);
        checkOutput("reset out_valid", 32'(outValid), 32'h0);
        checkOutput("reset p", 32'(prodP), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, gotP, lat, busyCnt);
            checkOutput("table p", 32'(gotP), 32'(vecs[i].expP));
            checkOutput("table latency", 32'(lat), 32'(refLatency(vecs[i].b)));
            checkOutput("table busy cycles", 32'(busyCnt), 32'(refLatency(vecs[i].b) - 1));
            releaseResult();
        end

        // Backpressure: result and handshake outputs hold while out_ready
        // is low, and new operands offered meanwhile are ignored.
        applyStimulus(8'h05, 8'h83, gotP, lat, busyCnt);
        checkOutput("bp first p", 32'(gotP), 32'h800F);
        for (int i = 0; i < 5; i++) begin
            inValid = 1'($urandom_range(0, 1));
            opA     = 8'($urandom);
            opB     = 8'($urandom);
            @(posedge clk); #1;
            checkOutput("bp p stable", 32'(prodP), 32'h800F);
            checkOutput("bp out_valid held", 32'(outValid), 32'h1);
            checkOutput("bp in_ready low", 32'(inReady), 32'h0);
        end
        inValid = 1'b0;
        releaseResult();
        checkOutput("bp p holds after release", 32'(prodP), 32'h800F);

        // Reset three cycles into BUSY aborts without emitting a result.
        @(posedge clk); #1;
        inValid = 1'b1;
        opA     = 8'h7F;
        opB     = 8'hFF;
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        checkOutput("pre-abort busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("abort in_ready", 32'(inReady), 32'h1);
        checkOutput("abort busy", 32'(busy), 32'h0);
        checkOutput("abort out_valid", 32'(outValid), 32'h0);
        checkOutput("abort p", 32'(prodP), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        seenValid = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            seenValid = seenValid | outValid;
        end
        checkOutput("no result after abort", 32'(seenValid), 32'h0);
        applyStimulus(8'h02, 8'h03, gotP, lat, busyCnt);
        checkOutput("post-abort p", 32'(gotP), 32'h0006);
        releaseResult();

        // Random operands against the arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i % 8 == 3) rb[6:0] = 7'h00;
            if (i % 8 == 5) ra[6:0] = 7'h00;
            applyStimulus(ra, rb, gotP, lat, busyCnt);
            checkOutput("random p", 32'(gotP), 32'(refMul(ra, rb)));
            checkOutput("random latency", 32'(lat), 32'(refLatency(rb)));
            releaseResult();
        end

        // W=4 instance: -7 x +1.
        @(posedge clk); #1;
        checkOutput("w4 in_ready", 32'(inReady4), 32'h1);
        inValid4 = 1'b1;
        opA4     = 4'hF;
        opB4     = 4'h1;
        @(posedge clk); #1;
        inValid4 = 1'b0;
        opA4     = 4'h0;
        lat4     = 1;
        busyCnt4 = busy4 ? 1 : 0;
        while (!outValid4 && lat4 < 50) begin
            @(posedge clk); #1;
            lat4++;
            if (busy4) busyCnt4++;
        end
        checkOutput("w4 out_valid", 32'(outValid4), 32'h1);
        checkOutput("w4 p", 32'(prodP4), 32'h87);
`ifdef SMAG_MUL_EARLY_TERM_EN
        checkOutput("w4 busy cycles", 32'(busyCnt4), 32'd1);
`else
        checkOutput("w4 busy cycles", 32'(busyCnt4), 32'd3);
`endif
        outReady4 = 1'b1;
        @(posedge clk); #1;
        outReady4 = 1'b0;
        checkOutput("w4 released", 32'(outValid4), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
